// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller
// Double-buffered frame with commit at frame wrap, ghost-suppression blanking and leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  output logic        ready,
  input  logic [15:0] data,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  output logic [3:0]  BCD,
  output logic        dp_n,
  output logic [3:0]  anode_n
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_BLANK} state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        act_data_q, act_data_d;
  logic [3:0]         act_dp_q, act_dp_d;
  logic               act_lz_q, act_lz_d;
  logic [15:0]        pend_data_q, pend_data_d;
  logic [3:0]         pend_dp_q, pend_dp_d;
  logic               pend_lz_q, pend_lz_d;
  logic               pend_vld_q, pend_vld_d;
  logic [3:0]         bcd_q, bcd_d;
  logic               dp_n_q, dp_n_d;
  logic               commit;
  logic               on_entry;
  logic [3:0]         suppress;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      act_data_q  <= 16'h0;
      act_dp_q    <= 4'h0;
      act_lz_q    <= 1'b0;
      pend_data_q <= 16'h0;
      pend_dp_q   <= 4'h0;
      pend_lz_q   <= 1'b0;
      pend_vld_q  <= 1'b0;
      bcd_q       <= 4'h0;
      dp_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_lz_q    <= act_lz_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_lz_q   <= pend_lz_d;
      pend_vld_q  <= pend_vld_d;
      bcd_q       <= bcd_d;
      dp_n_q      <= dp_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_lz_d    = act_lz_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    pend_vld_d  = pend_vld_q;
    bcd_d       = bcd_q;
    dp_n_d      = dp_n_q;
    commit      = 1'b0;
    on_entry    = 1'b0;

    case (state_q)
      S_IDLE: begin
        commit = pend_vld_q;
        if (enable) begin
          state_d  = S_ON;
          idx_d    = 2'd0;
          cnt_d    = '0;
          on_entry = 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d  = S_ON;
          idx_d    = idx_q + 2'd1;
          cnt_d    = '0;
          on_entry = 1'b1;
          // Swap frames only at the 3->0 wrap so a frame never tears mid-scan.
          commit   = pend_vld_q && (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase

    if (!enable) begin
      state_d  = S_IDLE;
      idx_d    = 2'd0;
      cnt_d    = '0;
      on_entry = 1'b0;
      commit   = commit && (state_q == S_IDLE);
    end

    if (commit) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      act_lz_d   = pend_lz_q;
      pend_vld_d = 1'b0;
    end

    if (load && !pend_vld_q) begin
      pend_data_d = data;
      pend_dp_d   = dp_en;
      pend_lz_d   = lz_blank;
      pend_vld_d  = 1'b1;
    end

    // Digit code follows the frame as it stands after any commit on this same edge.
    if (on_entry) begin
      bcd_d  = 4'(act_data_d >> {idx_d, 2'b00});
      dp_n_d = ~act_dp_d[idx_d];
    end
  end

  always_comb begin
    suppress[0] = 1'b0;
    suppress[1] = act_lz_q && (act_data_q[15:4] == 12'h0);
    suppress[2] = act_lz_q && (act_data_q[15:8] == 8'h0);
    suppress[3] = act_lz_q && (act_data_q[15:12] == 4'h0);
    anode_n = 4'hF;
    if (state_q == S_ON && !suppress[idx_q]) begin
      anode_n[idx_q] = 1'b0;
    end
    ready = ~pend_vld_q;
    BCD   = bcd_q;
    dp_n  = dp_n_q;
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - randomized bench for seven_seg_scan_ctrl against a timeline model
// The model tracks elapsed scan time and derives digit/lit/blank from plain arithmetic.
module tb_seven_seg_scan_ctrl;

  localparam int S = 4;
  localparam int B = 2;
  localparam int SLOT = S + B;
  localparam int P = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic        ready;
  logic [15:0] data;
  logic [3:0]  dp_en;
  logic        lz_blank;
  logic [3:0]  BCD;
  logic        dp_n;
  logic [3:0]  anode_n;

  int checks = 0;
  int errors = 0;

  bit m_run;
  int m_t;
  int m_act;
  int m_act_dp;
  bit m_act_lz;
  int m_pend;
  int m_pend_dp;
  bit m_pend_lz;
  bit m_pv;
  int m_bcd;
  bit m_dpn;

  seven_seg_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .ready(ready),
    .data(data), .dp_en(dp_en), .lz_blank(lz_blank), .BCD(BCD), .dp_n(dp_n),
    .anode_n(anode_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit_of(input int frame, input int d);
    return (frame / (1 << (4 * d))) % 16;
  endfunction

  function automatic logic [3:0] exp_anode();
    int pos, d;
    if (!m_run) return 4'hF;
    pos = m_t % P;
    d = pos / SLOT;
    if (pos % SLOT >= S) return 4'hF;
    if (d > 0 && m_act_lz && (m_act / (1 << (4 * d))) == 0) return 4'hF;
    return 4'(~(1 << d));
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_act = 0; m_act_dp = 0; m_act_lz = 0;
    m_pend = 0; m_pend_dp = 0; m_pend_lz = 0; m_pv = 0; m_bcd = 0; m_dpn = 1;
  endtask

  task automatic model_commit();
    if (m_pv) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_act_lz = m_pend_lz; m_pv = 0;
    end
  endtask

  task automatic model_show(input int d);
    m_bcd = digit_of(m_act, d);
    m_dpn = !((m_act_dp >> d) & 1);
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = !m_pv;
    if (!m_run) model_commit();
    if (!enable) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t = 0;
      model_show(0);
    end else begin
      m_t++;
      if (m_t % P == 0) model_commit();
      if (m_t % SLOT == 0) model_show((m_t % P) / SLOT);
    end
    if (load && rdy) begin
      m_pend = int'(data); m_pend_dp = int'(dp_en); m_pend_lz = lz_blank; m_pv = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("anode_n", 16'(anode_n), 16'(exp_anode()));
    chk("bcd", 16'(BCD), 16'(m_bcd));
    chk("dp_n", 16'(dp_n), 16'(m_dpn));
    chk("ready", 16'(ready), 16'(!m_pv));
  endtask

  task automatic drive(input bit en, input bit ld, input logic [15:0] d, input logic [3:0] dp, input bit lz);
    enable = en; load = ld; data = d; dp_en = dp; lz_blank = lz;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      drive(en, 1'b0, 16'h0, 4'h0, 1'b0);
      step();
    end
  endtask

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0070;
      2: return 16'(16'h000F & $urandom);
      3: return 16'(16'h00FF & $urandom);
      4: return 16'h1234;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int budget;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    #12;
    chk("rst_anode", 16'(anode_n), 16'hF);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_bcd", 16'(BCD), 16'h0);
    chk("rst_dp_n", 16'(dp_n), 16'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(3, 1'b0);

    drive(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
    step();
    run(60, 1'b1);

    drive(1'b1, 1'b1, 16'h0070, 4'h0, 1'b1);
    step();
    run(60, 1'b1);
    drive(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    step();
    run(60, 1'b1);

    run(SLOT + 1, 1'b1);
    drive(1'b1, 1'b1, 16'hAAAA, 4'hF, 1'b0);
    step();
    drive(1'b1, 1'b1, 16'h5555, 4'h0, 1'b1);
    step();
    run(50, 1'b1);

    run(2 * SLOT + 1, 1'b1);
    run(3, 1'b0);
    run(40, 1'b1);

    drive(1'b1, 1'b1, 16'h000C, 4'h1, 1'b0);
    step();
    run(40, 1'b1);

    budget = 0;
    while (!(m_run && (m_t % P) % SLOT < S - 1) && budget < 100) begin
      drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      step();
      budget++;
    end
    chk("find_on_window", 16'(budget < 100), 16'h1);
    drive(1'b1, 1'b1, 16'hBEEF, 4'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anode", 16'(anode_n), 16'hF);
    chk("async_ready", 16'(ready), 16'h1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(4, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0, pick_data(),
            4'($urandom), 1'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit is lit (SCAN_DIV >= 2).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1000, meaning all-anodes-off cycles between digits for ghost suppression (BLANK_CYC >= 1).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 Port enable, input, 1 bit: 1 = scan running; 0 = display dark, scan frozen.
REQ-006 Port load, input, 1 bit: write strobe, qualified by ready.
REQ-007 Port ready, output, 1 bit: 1 = new frame data accepted this cycle if load=1.
REQ-008 Port data, input, 16 bits: four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-009 Port dp_en, input, 4 bits: per-digit decimal point request, captured with data.
REQ-010 Port lz_blank, input, 1 bit: 1 = blank leading zeros, captured with data.
REQ-011 Port BCD, output, 4 bits: digit code to the shared BCD-to-7-segment decoder.
REQ-012 Port dp_n, output, 1 bit: active-low decimal point for the current digit (common-anode segment polarity).
REQ-013 Port anode_n, output, 4 bits: active-low digit select, one-hot-low or all-ones.

Function
REQ-014 FSM states SHALL be IDLE, ON, BLANK; digit index idx (2 bits); cycle counter cnt sized for max(SCAN_DIV, BLANK_CYC).
REQ-015 IDLE: anode_n=4'hF; enable=1 moves to ON with idx=0, cnt=0.
REQ-016 ON: anode_n bit idx=0, others 1; after SCAN_DIV cycles in ON the state goes to BLANK with cnt=0.
REQ-017 BLANK: anode_n=4'hF; after BLANK_CYC cycles the state goes to ON with idx=idx+1 mod 4 (3 wraps to 0).
REQ-018 BCD and dp_n SHALL be registered and change only on the ON-entry edge, so they are stable for the whole lit and blank window.
REQ-019 BCD SHALL equal active-frame digit idx; dp_n SHALL equal ~dp_en[idx].
REQ-020 Codes 10-15 SHALL be passed unchanged to BCD; the decoder renders them as minus.
REQ-021 With lz_blank=1, digit k (k=3..1) SHALL be suppressed (its anode stays 1 during ON) when it and all higher digits are 0; digit 0 is never suppressed.
REQ-022 Handshake: load=1 with ready=1 captures data, dp_en and lz_blank into the pending register; ready goes 0 the next cycle.
REQ-023 Load with ready=0 SHALL be ignored, with no state change.
REQ-024 Pending SHALL be committed to the active frame on the BLANK-to-ON edge where idx wraps 3 to 0 (no tearing); ready returns 1 on the cycle after commit.
REQ-025 While in IDLE (enable=0), a pending load SHALL commit on the next edge.
REQ-026 enable dropping to 0 in any state SHALL force IDLE next edge: anode_n=4'hF, idx=0, cnt=0; pending data is kept.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, cnt=0, anode_n=4'hF, BCD=4'h0, dp_n=1, ready=1, and active and pending frames to 0 with dp_en=0, lz_blank=0.
REQ-028 Reset asserted mid-scan SHALL darken all anodes immediately, without waiting for a clock edge.
REQ-029 After rst_n deasserts, the first scan SHALL start no earlier than the first edge with enable=1.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-030 Sequence test: reset, load data=16'h1234, dp_en=4'b0100, enable=1 -> anode_n sequence is 1110 x4, 1111 x2, 1101 x4, ...; BCD=4,3,2,1; dp_n=0 only on digit 2.
REQ-031 Leading-zero test: load 16'h0070, lz_blank=1 -> digits 3 and 2 are never lit, digit 1 shows 7, digit 0 shows 0; load 16'h0000 -> only digit 0 is lit.
REQ-032 Anti-tearing test: load 16'hAAAA during digit 1 ON -> ready=0 until commit; the new code appears first at the next digit 0 ON; ready=1 the following cycle.
REQ-033 Ignored-load test: a second load while ready=0 -> no effect on the active or pending frame.
REQ-034 Enable test: enable=0 mid-ON of digit 2 -> anode_n=1111 next edge; re-enable -> scan restarts at digit 0 with a full SCAN_DIV window.
REQ-035 Reset test: rst_n low between edges during ON -> anode_n=1111 and ready=1 with no clock edge; out-of-range digit 4'hC is passed to BCD unchanged.
